// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop process one operand
// bit per clock, LSB first; the WIDTH-bit sum and carry-out are registered.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               busy_d;
    logic               done_d;

    // a_sh doubles as the result register: sum bits enter at the MSB as
    // operand bits leave at the LSB, so after WIDTH shifts it holds the sum.
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               sum_bit_c;
    logic               carry_c;
    logic               last_bit_c;

    // Full-adder cell on the current LSBs
    assign sum_bit_c  = a_sh[0] ^ b_sh[0] ^ carry_q;
    assign carry_c    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry_q) | (b_sh[0] & carry_q);
    assign last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));

    // State and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next state; busy/done are decoded from the state being entered
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ADD;
                    busy_d  = 1'b1;
                end
            end
            ADD: begin
                if (last_bit_c) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand shift registers, carry, bit counter and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            S       <= '0;
            C       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                ADD: begin
                    a_sh    <= {sum_bit_c, a_sh[WIDTH-1:1]};
                    b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                    carry_q <= carry_c;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_bit_c) begin
                        S <= {sum_bit_c, a_sh[WIDTH-1:1]};
                        C <= carry_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder; expected results come from
// plain integer addition plus the documented timing of the handshake.
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c;

    int n_tests = 0;
    int n_fail  = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .S     (s),
        .C     (c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One addition: start accepted at the next posedge, then the run is
    // watched cycle by cycle. poke_cyc pulses start during ADD (0 = never),
    // poke_done raises start in the done cycle; scramble churns a/b.
    task automatic add_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input bit scramble, input int poke_cyc, input bit poke_done);
        logic [WIDTH:0]   exp_sum;
        logic [WIDTH-1:0] prev_s;
        logic             prev_c;
        int               busy_cnt;
        int               lat;
        bit               seen;
        exp_sum  = (WIDTH+1)'(op_a) + (WIDTH+1)'(op_b);
        prev_s   = s;
        prev_c   = c;
        busy_cnt = 0;
        lat      = 0;
        seen     = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        for (int i = 1; i <= 3 * int'(WIDTH) && !seen; i++) begin
            @(negedge clk);
            start = (poke_cyc != 0 && i == poke_cyc) ? 1'b1 : 1'b0;
            if (scramble || start) begin
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
            end
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                lat  = i;
                check("sum", 32'(s), 32'(exp_sum[WIDTH-1:0]));
                check("carry", 32'(c), 32'(exp_sum[WIDTH]));
                if (poke_done) start = 1'b1;
            end else begin
                check("s_hold", 32'(s), 32'(prev_s));
                check("c_hold", 32'(c), 32'(prev_c));
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(WIDTH + 1));
        check("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
        @(negedge clk);
        start = 1'b0;
        check("done_single", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n_done;
        int last_done;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_c", 32'(c), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases
        add_op(8'h00, 8'h00, 1'b0, 0, 1'b0);
        add_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        add_op(8'h80, 8'h80, 1'b0, 0, 1'b0);
        add_op(8'hA5, 8'h5A, 1'b1, 0, 1'b0);
        add_op(8'h21, 8'h13, 1'b0, 3, 1'b1);
        add_op(8'h0F, 8'h01, 1'b0, 0, 1'b0);

        // Reset in the middle of an addition
        add_op(8'h12, 8'h34, 1'b0, 0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a     = 8'h7F;
        b     = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_s", 32'(s), 32'd0);
        check("midrst_c", 32'(c), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("no_done_after_rst", 32'(n_done), 32'd0);
        add_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);

        // Random operands with a/b churning during ADD
        for (int k = 0; k < 20; k++) begin
            add_op(WIDTH'($urandom), WIDTH'($urandom), 1'b1, 0, 1'b0);
        end

        // Start held high: one result every WIDTH+2 cycles
        start     = 1'b1;
        a         = 8'h33;
        b         = 8'h44;
        n_done    = 0;
        last_done = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 30) start = 1'b0;
            if (done) begin
                n_done++;
                check("b2b_sum", 32'(s), 32'h77);
                check("b2b_carry", 32'(c), 32'd0);
                if (last_done != 0) check("b2b_period", 32'(i - last_done), 32'(WIDTH + 2));
                last_done = i;
            end
        end
        repeat (12) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("b2b_count", 32'(n_done), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  request to add the a, b operands; sampled on rising clk.
REQ-005 Port: a  input  WIDTH  operand A, sampled only in the cycle start is accepted.
REQ-006 Port: b  input  WIDTH  operand B, sampled only in the cycle start is accepted.
REQ-007 Port: busy  output  1  high while an addition is in progress.
REQ-008 Port: done  output  1  single-cycle pulse marking a new result on S/C.
REQ-009 Port: S  output  WIDTH  registered sum of the last completed addition.
REQ-010 Port: C  output  1  registered carry-out of the last completed addition.

Function
REQ-011 The block SHALL add bit-serially, LSB first, one bit per clock, using one half-adder pair (full-adder cell) plus a carry register.
REQ-012 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-013 IDLE: start=1 at a rising edge SHALL latch a and b into internal shift registers, clear the carry register, clear the bit counter and enter ADD.
REQ-014 IDLE: start=0 SHALL hold the state.
REQ-015 ADD, each edge: sum_i = a_i ^ b_i ^ c and c <= majority(a_i, b_i, c) SHALL be computed, sum_i shifted into the internal result register, and the counter incremented.
REQ-016 ADD: the edge that processes bit WIDTH-1 SHALL copy the result register to S and the final carry to C, and enter DONE.
REQ-017 DONE: done SHALL be 1 for exactly one cycle, and the next edge SHALL return to IDLE unconditionally.
REQ-018 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-019 busy SHALL be 1 exactly in state ADD (WIDTH cycles) and 0 in IDLE and DONE.
REQ-020 start asserted in ADD or DONE SHALL be ignored, with no effect on operands, state or outputs.
REQ-021 Back-to-back operation: start held high continuously SHALL be accepted at the first IDLE edge after DONE, giving a period of WIDTH+2 cycles per addition.
REQ-022 S and C SHALL hold their previous value throughout ADD and change only at the REQ-016 edge.
REQ-023 Changes on a and b after acceptance SHALL not affect the in-flight result.
REQ-024 The result SHALL equal {C,S} = a + b exactly (WIDTH+1-bit sum), with no saturation.

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock, force state=IDLE, busy=0, done=0, S=0, C=0, and clear the carry, counter and operand registers.
REQ-026 Reset asserted mid-ADD or in DONE SHALL discard the in-flight addition, with no done pulse and no S/C update.
REQ-027 After rst_n deasserts, the first accepted start SHALL behave exactly as in REQ-013..REQ-018.

Verification (WIDTH=8)
REQ-028 Reset, then start with a=0x00, b=0x00 -> done 8 edges after acceptance, S=0x00, C=0, busy high for exactly 8 cycles.
REQ-029 a=0xFF, b=0x01 -> S=0x00, C=1; separately a=0x80, b=0x80 -> S=0x00, C=1.
REQ-030 a=0xA5, b=0x5A, then a/b changed to 0x00 during ADD -> S=0xFF, C=0, with S/C unchanged until the done cycle.
REQ-031 start pulsed again at ADD cycles 3 and DONE -> ignored; exactly one done pulse; a subsequent IDLE start with 0x0F+0x01 -> S=0x10, C=0.
REQ-032 rst_n low for 1 cycle at ADD cycle 4 of 0x7F+0x01 -> outputs 0 immediately, no done; next start 0x7F+0x01 -> S=0x80, C=0.
REQ-033 start held high for 30 cycles with a=0x33, b=0x44 -> done pulses every 10 cycles, each with S=0x77, C=0.
